// File: rtl/jpeg2bmp_idct_descale_clamp.sv
// jpeg2bmp_idct_descale_clamp
// Accumulates NTERMS signed IDCT products into one column dot product.
// The sum is rounded half-up, descaled by an arithmetic right shift and
// level-shifted by BIAS. The result is saturated to an unsigned OUT_WIDTH-bit
// pixel and emitted through a single output register with a valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset (takes priority over ce)
//   ce          stage enable; 0 freezes every register and blocks accepts
//   in_data     signed IN_WIDTH-bit product
//   in_valid    in_data is valid
//   in_ready    term is accepted this cycle (combinational)
//   out_data    clamped pixel
//   out_clip    out_data was saturated
//   out_valid   out_data/out_clip valid
//   out_ready   downstream accepts the output
//   clip_count  saturating count of clipped results since reset
module jpeg2bmp_idct_descale_clamp #(
  parameter int unsigned IN_WIDTH  = 41,
  parameter int unsigned NTERMS    = 8,
  parameter int unsigned SHIFT     = 18,
  parameter int          BIAS      = 128,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_clip,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          clip_count
);

  localparam int unsigned CNT_W = $clog2(NTERMS);
  localparam int unsigned ACC_W = IN_WIDTH + CNT_W;
  // Two guard bits: one so the rounding add cannot overflow, one for the bias add.
  localparam int unsigned RW    = ACC_W + 2;

  localparam logic signed [RW-1:0] HALF   = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] BIAS_V = RW'(BIAS);
  localparam logic signed [RW-1:0] MAX_V  = RW'((2 ** OUT_WIDTH) - 1);
  localparam logic [OUT_WIDTH-1:0] PIX_MAX = OUT_WIDTH'((2 ** OUT_WIDTH) - 1);
  localparam logic [15:0]          CLIP_SAT = 16'hFFFF;

  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_clip_q, out_clip_d;
  logic [15:0]             clip_cnt_q, clip_cnt_d;

  logic                    last_term;
  logic                    accept;
  logic                    load;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    r;
  logic signed [RW-1:0]    v;
  logic [OUT_WIDTH-1:0]    pix;
  logic                    clip;

  // Handshake: only the final term of a group waits for room in the output register.
  assign last_term = (count_q == CNT_W'(NTERMS - 1));
  assign in_ready  = ce & (~last_term | ~out_valid_q | out_ready);
  assign accept    = in_ready & in_valid;
  assign load      = accept & last_term;

  // Sum including the current term; the first term of a group replaces the accumulator.
  always_comb begin
    in_ext = ACC_W'($signed(in_data));
    if (count_q == '0) begin
      sum = in_ext;
    end else begin
      sum = acc_q + in_ext;
    end
  end

  // Round half-up, descale, level-shift and saturate.
  always_comb begin
    rnd  = RW'(sum) + HALF;
    r    = rnd >>> SHIFT;
    v    = r + BIAS_V;
    pix  = v[OUT_WIDTH-1:0];
    clip = 1'b0;
    if (v[RW-1]) begin
      pix  = '0;
      clip = 1'b1;
    end else if (v > MAX_V) begin
      pix  = PIX_MAX;
      clip = 1'b1;
    end
  end

  // Next-state for accumulator, term counter and output register.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_clip_d  = out_clip_q;
    clip_cnt_d  = clip_cnt_q;

    if (accept) begin
      acc_d   = sum;
      count_d = last_term ? '0 : count_q + CNT_W'(1);
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = pix;
      out_clip_d  = clip;
      if (clip && (clip_cnt_q != CLIP_SAT)) begin
        clip_cnt_d = clip_cnt_q + 16'd1;
      end
    end else if (ce && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_clip_q  <= 1'b0;
      clip_cnt_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_clip_q  <= out_clip_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_clip   = out_clip_q;
  assign clip_count = clip_cnt_q;

endmodule

// File: doc/jpeg2bmp_idct_descale_clamp.md
Name: jpeg2bmp_idct_descale_clamp

Overview:
- Downstream consumer of the IDCT coefficient multiplier: 41-bit signed product in, one 8-bit pixel out.
- Accepts a stream of signed 41-bit products and accumulates NTERMS products per output sample (one IDCT column dot product).
- Rounds, descales by arithmetic right shift, adds the level-shift bias and saturates to an unsigned 8-bit pixel.
- Emits one sample per group over a valid/ready handshake, feeding the block-to-raster pixel buffer.

Parameters:
- IN_WIDTH, 41, product width; matches the multiplier output.
- NTERMS, 8, products summed per output sample; power of two, at least 2.
- SHIFT, 18, descale shift (CONST_BITS 13 + PASS1_BITS 2 + 3); at least 1.
- BIAS, 128, level shift added after descale.
- OUT_WIDTH, 8, output pixel width; clamp range is 0 to 2^OUT_WIDTH-1.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-high reset.
- ce, input, 1, global stage enable; ce=0 freezes all state.
- in_data, input, IN_WIDTH, signed product.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- out_data, output, OUT_WIDTH, unsigned clamped pixel.
- out_clip, output, 1, out_data was saturated (high or low).
- out_valid, output, 1, out_data and out_clip are valid.
- out_ready, input, 1, downstream accepts the output.
- clip_count, output, 16, saturating count of clipped samples since reset.

Behaviour:
- Reset (synchronous, active-high, takes priority over ce) sets:
  - accumulator = 0, term counter = 0, out_valid = 0, out_data = 0, out_clip = 0, clip_count = 0.
  - Reset mid-group discards the partial sum and any pending output.
- Accumulator width is ACC_W = IN_WIDTH + log2(NTERMS) = 44. It is signed, cannot overflow, and uses sign-extended adds.
- Accept: a term is accepted when ce & in_valid & in_ready.
  - Term counter runs 0..NTERMS-1 and wraps to 0 after the last term.
  - The first term of a group loads the accumulator (no clear cycle). Later terms add to it.
- in_ready = ce & (count != NTERMS-1 | !out_valid | out_ready).
  - Non-final terms are always accepted while ce=1, even with the output stalled.
  - The final term stalls only while the output register is occupied and not draining.
- Final term accepted: the result is computed from sum = acc + in_data and registered the next edge.
  - Latency: out_valid rises 1 cycle after the final term is accepted.
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, which is round-half-up, including negatives.
  - v = r + BIAS.
  - If v < 0: out_data = 0, out_clip = 1.
  - If v > 2^OUT_WIDTH-1: out_data = 2^OUT_WIDTH-1, out_clip = 1.
  - Otherwise: out_data = v[OUT_WIDTH-1:0], out_clip = 0.
- clip_count increments on each registered clipped result and holds at 16'hFFFF.
- Output register:
  - out_valid clears on ce & out_valid & out_ready unless a new result loads the same edge.
  - Simultaneous drain and load gives back-to-back output with no bubble.
  - out_data and out_clip hold stable while out_valid=1 and out_ready=0.
- ce=0:
  - No term is accepted (in_ready=0).
  - The output register neither loads nor drains; all registers hold.
- out_ready while out_valid=0 is ignored. in_data is ignored when not accepted.

Test Plan:
1. Reset, then 8 terms of 262144 (2^18), out_ready=1 -> one output 1 cycle after the 8th accept: out_data=136, out_clip=0.
2. Rounding, single non-zero term per group with the rest 0:
   - sum 131072 -> 129.
   - sum 131071 -> 128.
   - sum -131072 -> 128.
   - sum -131073 -> 127.
   - All with out_clip=0.
3. Clamping:
   - 8 terms of 2^25 (r=1024) -> out_data=255, out_clip=1.
   - 8 terms of -2^25 -> out_data=0, out_clip=1.
   - clip_count then reads 2.
4. Backpressure:
   - Group A completes with out_ready=0.
   - Group B terms 1-7 are accepted; term 8 sees in_ready=0 and is held.
   - Raise out_ready -> A drains, B's final term is accepted the same cycle, B appears next cycle, values correct.
5. ce=0 pulses mid-group and mid-output-stall -> no accepts, counter, accumulator and outputs frozen; final results identical to the ce=1 run.
6. Reset asserted after term 5 of a group, then a fresh 8-term group of 2^18 -> output 136 (no residue); out_valid=0 during and immediately after reset.
